// File: rtl/dtx_pkg.sv
// Shared definitions for the dtx serial frame transmitter.
//   state_e     : transmitter FSM state encoding
//   LINE_IDLE   : idle line sample word (line rests high)
//   expand_pair : maps two line bits onto 8 oversampled samples
package dtx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOdd,
    StEven,
    StTail,
    StGap
  } state_e;

  localparam logic [7:0] LINE_IDLE = 8'hFF;

  // Each line bit occupies 4 samples; the first bit lands in the oldest (upper) samples.
  function automatic logic [7:0] expand_pair(input logic b_first, input logic b_second);
    return {{4{b_first}}, {4{b_second}}};
  endfunction

endpackage

// File: rtl/dtx_if.sv
// Payload nibble stream into the transmitter (valid/ready).
//   s_d     : payload nibble, bit 3 sent first
//   s_v     : s_d valid
//   s_last  : nibble closes the frame
//   s_ready : nibble consumed on an edge where s_v && s_ready
interface dtx_if;

  logic [3:0] s_d;
  logic       s_v;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_d,
    output s_v,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_d,
    input  s_v,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/dtx.sv
// Serial frame transmitter: start bit (0), MSB-first nibbles, stop bit (1), then an
// idle gap. Two line bits per clock, each replicated on 4 samples of the 8-sample word.
//   c      : 400 MHz clock
//   rst_n  : asynchronous active-low reset
//   s      : payload nibble stream (slave side)
//   o      : registered line samples, bit 7 oldest
//   busy   : frame or gap in progress
//   err    : one-cycle underrun pulse, aligned with the truncating stop word
module dtx
  import dtx_pkg::*;
#(
  parameter int unsigned MAX_NIB = 10,
  parameter int unsigned MIN_GAP = 8
) (
  input  logic       c,
  input  logic       rst_n,
  dtx_if.slave       s,
  output logic [7:0] o,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CntW = $clog2(MAX_NIB + 1);
  localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  state_e          state_q, state_d;
  logic [2:0]      hold_q, hold_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      o_q, o_d;
  logic            err_q, err_d;
  logic            en_q;
  logic            more_ok;
  logic            xfer;

  // The state names the word currently on the line: the start word shares the EVEN
  // shape (previous bit, next MSB) with the start bit standing in for h0.
  assign more_ok   = !last_q && (cnt_q < CntW'(MAX_NIB));
  // en_q keeps s_ready low during reset and releases it on the first edge afterwards.
  assign s.s_ready = en_q && ((state_q == StIdle) || ((state_q == StOdd) && more_ok));
  assign xfer      = s.s_v && s.s_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gap_d   = gap_q;
    o_d     = LINE_IDLE;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          o_d     = expand_pair(1'b0, s.s_d[3]);
          hold_d  = s.s_d[2:0];
          cnt_d   = CntW'(1);
          last_d  = s.s_last;
          state_d = StEven;
        end
      end
      StEven: begin
        o_d     = expand_pair(hold_q[2], hold_q[1]);
        state_d = StOdd;
      end
      StOdd: begin
        if (xfer) begin
          o_d     = expand_pair(hold_q[0], s.s_d[3]);
          hold_d  = s.s_d[2:0];
          cnt_d   = cnt_q + CntW'(1);
          last_d  = s.s_last;
          state_d = StEven;
        end else begin
          // Close with a stop bit; flag underrun only when the frame wanted more data.
          o_d     = expand_pair(hold_q[0], 1'b1);
          err_d   = more_ok;
          state_d = StTail;
        end
      end
      StTail: begin
        if (MIN_GAP == 0) begin
          state_d = StIdle;
        end else begin
          gap_d   = GapW'(MIN_GAP - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      gap_q   <= '0;
      o_q     <= LINE_IDLE;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      o_q     <= o_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  assign o    = o_q;
  assign err  = err_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_dtx.sv
module tb_dtx;

  logic       c;
  logic       rst_n;
  logic [7:0] o;
  logic       busy;
  logic       err;

  dtx_if s_if ();

  dtx #(
    .MAX_NIB(10),
    .MIN_GAP(8)
  ) dut (
    .c    (c),
    .rst_n(rst_n),
    .s    (s_if),
    .o    (o),
    .busy (busy),
    .err  (err)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int checks;
  int failures;

  // Loopback receiver: samples the middle of each 4-sample bit, 3-nibble frames.
  logic        dec_en;
  logic        dec_act;
  int          dec_n;
  logic [11:0] dec_sr;
  int          rep_cnt;
  logic [11:0] rep_word;

  // Expected line word k of a frame with n nibbles packed MSB-first in nv.
  function automatic logic bit_at(input logic [63:0] nv, input int n, input int j);
    if (j == 0) return 1'b0;
    if (j <= 4 * n) return nv[4 * n - j];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_word(input logic [63:0] nv, input int n, input int k);
    logic a;
    logic b;
    a = bit_at(nv, n, 2 * k);
    b = bit_at(nv, n, 2 * k + 1);
    return {{4{a}}, {4{b}}};
  endfunction

  task automatic dec_step();
    logic b;
    if (!rst_n) begin
      dec_act = 1'b0;
      return;
    end
    for (int bi = 0; bi < 2; bi++) begin
      b = (bi == 0) ? o[5] : o[1];
      if (!dec_act) begin
        if (!b) begin
          dec_act = 1'b1;
          dec_n   = 0;
          dec_sr  = '0;
        end
      end else if (dec_n < 12) begin
        dec_sr = {dec_sr[10:0], b};
        dec_n++;
      end else begin
        if (b) begin
          rep_cnt++;
          rep_word = dec_sr;
        end
        dec_act = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
    if (dec_en) dec_step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    s_if.s_v = 1'b0;
    s_if.s_d = 4'h0;
    s_if.s_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o !== 8'hFF || s_if.s_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state o=%h rdy=%b busy=%b err=%b want o=ff rdy=0 busy=0 err=0",
               o, s_if.s_ready, busy, err);
    end
    tick();
    rst_n = 1'b1;
    checks++;
    if (s_if.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b want=0", s_if.s_ready);
    end
    tick();
    checks++;
    if (s_if.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge got=%b want=1", s_if.s_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o !== 8'hFF || busy !== 1'b0 || s_if.s_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_cycle%0d o=%h busy=%b rdy=%b want o=ff busy=0 rdy=1",
                 i, o, busy, s_if.s_ready);
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [7:0] exp_o   [5] = '{8'h0F, 8'h0F, 8'h00, 8'hF0, 8'hFF};
    logic       exp_rdy [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    s_if.s_v = 1'b1; s_if.s_d = 4'hA; s_if.s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        s_if.s_d = 4'h5; s_if.s_last = 1'b1;
      end
      if (i == 2) s_if.s_v = 1'b0;
      checks++;
      if (o !== exp_o[i] || s_if.s_ready !== exp_rdy[i] || busy !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL a5_word%0d o=%h rdy=%b busy=%b err=%b want o=%h rdy=%b busy=1 err=0",
                 i, o, s_if.s_ready, busy, err, exp_o[i], exp_rdy[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (o !== 8'hFF || s_if.s_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL a5_gap%0d o=%h rdy=%b busy=%b want o=ff rdy=0 busy=1",
                 i, o, s_if.s_ready, busy);
      end
    end
    tick();
    checks++;
    if (o !== 8'hFF || s_if.s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL a5_back_idle o=%h rdy=%b busy=%b want o=ff rdy=1 busy=0",
               o, s_if.s_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_o [3] = '{8'h00, 8'h00, 8'h0F};
    s_if.s_v = 1'b1; s_if.s_d = 4'h0; s_if.s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      s_if.s_v = 1'b0;
      checks++;
      if (o !== exp_o[i] || err !== 1'b0) begin
        failures++;
        $display("FAIL single_word%0d o=%h err=%b want o=%h err=0", i, o, err, exp_o[i]);
      end
    end
    tick();
    checks++;
    if (o !== 8'hFF || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gap o=%h busy=%b want o=ff busy=1", o, busy);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (busy !== 1'b0 || s_if.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle busy=%b rdy=%b want busy=0 rdy=1", busy, s_if.s_ready);
    end
  endtask

  task automatic test_max_nib();
    logic [63:0] nv1 = 64'h0123456789;
    logic [63:0] nv2 = 64'hAB;
    logic [7:0]  exp_o;
    logic        acc;
    int          ptr = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      s_if.s_v    = (ptr < 12);
      s_if.s_d    = 4'(ptr);
      s_if.s_last = 1'b0;
      acc = s_if.s_v && s_if.s_ready;
      tick();
      if (acc) ptr++;
      if (cyc <= 20)      exp_o = exp_word(nv1, 10, cyc);
      else if (cyc <= 29) exp_o = 8'hFF;
      else                exp_o = exp_word(nv2, 2, cyc - 30);
      checks++;
      if (o !== exp_o) begin
        failures++;
        $display("FAIL max_word%0d o=%h want=%h", cyc, o, exp_o);
      end
      if (cyc < 34) begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL max_err%0d err=%b want=0", cyc, err);
        end
      end
    end
    s_if.s_v = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (busy !== 1'b0 || ptr !== 12) begin
      failures++;
      $display("FAIL max_end busy=%b taken=%0d want busy=0 taken=12", busy, ptr);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] exp_o   [4] = '{8'h0F, 8'hF0, 8'h0F, 8'hFF};
    logic       exp_err [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    s_if.s_v = 1'b1; s_if.s_d = 4'hC; s_if.s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_if.s_v = 1'b0;
      checks++;
      if (o !== exp_o[i] || err !== exp_err[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL underrun_word%0d o=%h err=%b busy=%b want o=%h err=%b busy=1",
                 i, o, err, busy, exp_o[i], exp_err[i]);
      end
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL underrun_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_loopback_reset();
    logic [3:0] nibs  [7] = '{4'h3, 4'h9, 4'h6, 4'h1, 4'h2, 4'h4, 4'h8};
    logic       lasts [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       acc;
    logic       rst_done = 1'b0;
    logic       err_seen = 1'b0;
    int         ptr = 0;
    dec_act = 1'b0; dec_n = 0; dec_sr = '0; rep_cnt = 0; rep_word = '0;
    dec_en  = 1'b1;
    for (int cyc = 0; cyc < 80 && !rst_done; cyc++) begin
      s_if.s_v    = (ptr < 7);
      s_if.s_d    = (ptr < 7) ? nibs[ptr] : 4'h0;
      s_if.s_last = (ptr < 7) ? lasts[ptr] : 1'b0;
      acc = s_if.s_v && s_if.s_ready;
      tick();
      if (acc) ptr++;
      if (err) err_seen = 1'b1;
      if (ptr == 5) begin
        rst_n    = 1'b0;
        s_if.s_v = 1'b0;
        #1;
        checks++;
        if (o !== 8'hFF || busy !== 1'b0 || s_if.s_ready !== 1'b0 || err !== 1'b0) begin
          failures++;
          $display("FAIL loop_reset_async o=%h busy=%b rdy=%b err=%b want ff 0 0 0",
                   o, busy, s_if.s_ready, err);
        end
        for (int i = 0; i < 2; i++) begin
          tick();
          checks++;
          if (o !== 8'hFF) begin
            failures++;
            $display("FAIL loop_reset_line%0d o=%h want=ff", i, o);
          end
        end
        rst_n    = 1'b1;
        rst_done = 1'b1;
      end
    end
    checks++;
    if (!rst_done) begin
      failures++;
      $display("FAIL loop_timeout taken=%0d want=5 within 80 cycles", ptr);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (err) err_seen = 1'b1;
    end
    dec_en = 1'b0;
    checks++;
    if (rep_cnt !== 1 || rep_word !== 12'h396) begin
      failures++;
      $display("FAIL loop_decode frames=%0d word=%h want frames=1 word=396", rep_cnt, rep_word);
    end
    checks++;
    if (err_seen !== 1'b0) begin
      failures++;
      $display("FAIL loop_err got=1 want=0");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    dec_en   = 1'b0;
    dec_act  = 1'b0;
    dec_n    = 0;
    dec_sr   = '0;
    rep_cnt  = 0;
    rep_word = '0;
    test_reset();
    test_frame_a5();
    test_single();
    test_max_nib();
    test_underrun();
    test_loopback_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
